data_mem_lsu: RTL and testbench
===============================

Name: data_mem_lsu

Overview:
- Parametrised successor to the single-cycle data memory: a byte-addressed, little-endian RAM with sized loads and stores (byte, half, word), sign/zero extension, and alignment checking.
- A valid/ready request port feeds a fixed-latency response pipeline.
- An optional reset-triggered clear engine zeroes the array one word per cycle instead of in a single cycle.
- Sits between the core's execute/memory stage and the data RAM.

Parameters:
- DATA_WIDTH, 32, word width in bits; legal values 32 or 64; NB = DATA_WIDTH/8 byte lanes.
- ADDR_WIDTH, 10, byte-address width; array holds 2^ADDR_WIDTH bytes = 2^ADDR_WIDTH/NB words.
- READ_LATENCY, 1, cycles from request acceptance to response; legal 1..4.
- CLEAR_ON_RESET, 1, when 1 the reset starts the clear sequence; when 0 contents are retained through reset.
- MEM_INIT_FILE, "", hex image loaded at time zero, one byte per entry, lowest address first; empty string means no load.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- i_req_valid  in  1  request present.
- o_req_ready  out  1  request can be accepted this cycle.
- i_req_we  in  1  1 = store, 0 = load.
- i_req_addr  in  ADDR_WIDTH  byte address.
- i_req_size  in  2  00 byte, 01 half, 10 word(32b), 11 dword (legal only when DATA_WIDTH=64).
- i_req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- i_req_wdata  in  DATA_WIDTH  store data; the operand is the low-order bytes.
- o_rsp_valid  out  1  response strobe, one cycle per accepted request.
- o_rsp_rdata  out  DATA_WIDTH  load result, extended to DATA_WIDTH; 0 for stores and errors.
- o_rsp_err  out  1  request misaligned or illegal size; qualified by o_rsp_valid.
- o_clearing  out  1  clear sequence in progress.

Behaviour:
- Reset values: o_req_ready=0, o_rsp_valid=0, o_rsp_rdata=0, o_rsp_err=0. o_clearing=1 if CLEAR_ON_RESET else 0. All pipeline valid bits are cleared.
- FSM has two states, CLEAR and IDLE.
  - rst drives the FSM to CLEAR if CLEAR_ON_RESET, otherwise to IDLE.
  - CLEAR writes 0 to word index cnt each cycle, cnt counting 0 up to last word.
  - After the last word is written, the FSM moves to IDLE on the next edge.
  - Clear takes exactly 2^ADDR_WIDTH/NB cycles.
  - o_req_ready = (state==IDLE) and not rst.
- A request is accepted on the edge where i_req_valid and o_req_ready are both high; one request per cycle, no internal queue.
- Alignment rule: size n requires addr mod 2^n == 0. Size 11 with DATA_WIDTH=32 is an error.
- Error requests:
  - no array write;
  - a response is still generated with rdata=0 and err=1.
- Store:
  - writes only the addressed byte lanes at the accept edge;
  - lane k of the word receives wdata byte (k - addr mod NB);
  - other lanes are unchanged;
  - a store response has rdata=0 and err=0.
- Load:
  - the word is read at the accept edge;
  - the addressed bytes are shifted to bit 0 and extended per i_req_unsigned;
  - the result is presented after READ_LATENCY edges.
- Little-endian throughout: byte at address A occupies bits [8*(A mod NB)+7 : 8*(A mod NB)] of its word.
- Response timing: o_rsp_valid rises exactly READ_LATENCY cycles after acceptance. Back-to-back requests give back-to-back responses, in order. There is no response backpressure.
- Store followed by a load of the same bytes on the next cycle returns the new data (write-before-read ordering across edges).
- Reset mid-operation:
  - in-flight responses are dropped and o_rsp_valid is 0 from the edge after rst;
  - a clear in progress restarts at word 0;
  - rst held for multiple cycles holds cnt at 0.
- Address wrap: none; the full ADDR_WIDTH space maps one-to-one onto the array.

Test Plan:
- ADDR_WIDTH=6, DATA_WIDTH=32, CLEAR_ON_RESET=1: pulse rst for 1 cycle -> o_clearing high for exactly 16 cycles, o_req_ready rises on cycle 17, every word reads 0x00000000.
- Store word 0xA1B2C3D4 @0x08, then load byte unsigned @0x09 -> rdata=0x000000C3; load byte signed @0x08 -> 0xFFFFFFD4; load half signed @0x0A -> 0xFFFFA1B2.
- Store half 0xBEEF @0x0E over existing word 0x11223344 @0x0C, then load word @0x0C -> 0xBEEF3344.
- Misaligned half store @0x05 and word load @0x06 -> both responses err=1, rdata=0; word @0x04 is unchanged.
- READ_LATENCY=3, four back-to-back loads -> o_rsp_valid high on cycles 3..6 after the first accept, data in request order.
- Assert rst while two loads are in flight and mid-clear -> no o_rsp_valid after reset, o_clearing restarts, a full 16-cycle clear follows.

Source files
------------

// File: rtl/data_mem_lsu.sv
// data_mem_lsu: byte-addressed little-endian RAM with sized loads/stores, fixed-latency responses and a word-per-cycle clear engine
module data_mem_lsu #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int READ_LATENCY = 1,
  parameter int CLEAR_ON_RESET = 1,
  parameter string MEM_INIT_FILE = ""
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_we,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [1:0]            i_req_size,
  input  logic                  i_req_unsigned,
  input  logic [DATA_WIDTH-1:0] i_req_wdata,
  output logic                  o_rsp_valid,
  output logic [DATA_WIDTH-1:0] o_rsp_rdata,
  output logic                  o_rsp_err,
  output logic                  o_clearing
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int LB = $clog2(NB);
  localparam int WA = ADDR_WIDTH - LB;
  typedef enum logic {CLEAR, IDLE} state_t;
  state_t state, nxt;
  logic [WA-1:0] cnt;
  logic [7:0] mem [2**ADDR_WIDTH];
  logic [WA-1:0] widx;
  logic [LB-1:0] off;
  logic [2:0] mask;
  logic err, acc, sgn;
  logic [NB-1:0] be;
  logic [DATA_WIDTH-1:0] ws, rword, sh, keep, ld;
  logic pv [READ_LATENCY];
  logic pe [READ_LATENCY];
  logic [DATA_WIDTH-1:0] pd [READ_LATENCY];
  assign widx = i_req_addr[ADDR_WIDTH-1:LB];
  assign off = i_req_addr[LB-1:0];
  assign mask = 3'((4'd1 << i_req_size) - 4'd1);
  assign err = (i_req_size == 2'd3 && NB == 4) || |(i_req_addr[2:0] & mask);
  assign o_req_ready = state == IDLE && !rst;
  assign acc = i_req_valid && o_req_ready;
  assign o_clearing = state == CLEAR;
  assign be = NB'(((32'd1 << (32'd1 << i_req_size)) - 32'd1) << off);
  assign ws = i_req_wdata << {off, 3'b000};
  always_comb begin
    rword = '0;
    for (int k = 0; k < NB; k++) rword[8*k+:8] = mem[{widx, LB'(k)}];
  end
  always_comb begin
    sh = rword >> {off, 3'b000};
    keep = i_req_size == 2'd0 ? DATA_WIDTH'(8'hFF) :
           i_req_size == 2'd1 ? DATA_WIDTH'(16'hFFFF) :
           i_req_size == 2'd2 ? DATA_WIDTH'(32'hFFFF_FFFF) : '1;
    sgn = !i_req_unsigned && (i_req_size == 2'd0 ? sh[7] : i_req_size == 2'd1 ? sh[15] :
                              i_req_size == 2'd2 ? sh[31] : 1'b0);
    ld = (sh & keep) | (sgn ? ~keep : '0);
  end
  always_comb nxt = state == CLEAR && cnt == '1 ? IDLE : state;
  always_ff @(posedge clk)
    if (rst) begin
      state <= CLEAR_ON_RESET != 0 ? CLEAR : IDLE;
      cnt <= '0;
    end else begin
      state <= nxt;
      cnt <= state == CLEAR ? cnt + 1'b1 : '0;
    end
  always_ff @(posedge clk)
    for (int k = 0; k < NB; k++)
      if (state == CLEAR) mem[{cnt, LB'(k)}] <= 8'h00;
      else if (acc && i_req_we && !err && be[k]) mem[{widx, LB'(k)}] <= ws[8*k+:8];
  always_ff @(posedge clk)
    if (rst) begin
      for (int k = 0; k < READ_LATENCY; k++) begin
        pv[k] <= 1'b0;
        pe[k] <= 1'b0;
        pd[k] <= '0;
      end
    end else begin
      pv[0] <= acc;
      pe[0] <= acc && err;
      pd[0] <= acc && !err && !i_req_we ? ld : '0;
      for (int k = 1; k < READ_LATENCY; k++) begin
        pv[k] <= pv[k-1];
        pe[k] <= pe[k-1];
        pd[k] <= pd[k-1];
      end
    end
  assign o_rsp_valid = pv[READ_LATENCY-1];
  assign o_rsp_err = pe[READ_LATENCY-1];
  assign o_rsp_rdata = pd[READ_LATENCY-1];
endmodule

// File: tb/tb_data_mem_lsu.sv
// tb_data_mem_lsu: self-checking bench with a byte-array reference model and per-cycle response compare
module tb_data_mem_lsu;
  localparam int RL = 3;
  logic clk = 0, rst = 1;
  logic i_req_valid = 0, i_req_we = 0, i_req_unsigned = 0;
  logic [5:0] i_req_addr = 0;
  logic [1:0] i_req_size = 0;
  logic [31:0] i_req_wdata = 0;
  logic o_req_ready, o_rsp_valid, o_rsp_err, o_clearing;
  logic [31:0] o_rsp_rdata;
  data_mem_lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .READ_LATENCY(RL), .CLEAR_ON_RESET(1), .MEM_INIT_FILE("")) dut (
    .clk(clk), .rst(rst), .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_we(i_req_we),
    .i_req_addr(i_req_addr), .i_req_size(i_req_size), .i_req_unsigned(i_req_unsigned), .i_req_wdata(i_req_wdata),
    .o_rsp_valid(o_rsp_valid), .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err), .o_clearing(o_clearing));
  always #5 clk = ~clk;
  typedef struct {int due; logic [31:0] d; logic e;} rsp_t;
  rsp_t q[$];
  rsp_t obs[$];
  logic [7:0] mm [64];
  int cyc = 0, clear_left = 0, total = 0, fails = 0;
  bit on = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  task automatic model_req();
    int n;
    bit e;
    longint v;
    n = 1 << i_req_size;
    e = i_req_size == 2'd3 || (int'(i_req_addr) % n) != 0;
    v = 0;
    if (!e && i_req_we)
      for (int i = 0; i < n; i++) mm[int'(i_req_addr) + i] = i_req_wdata[8*i+:8];
    else if (!e) begin
      for (int i = 0; i < n; i++) v = v | (longint'(mm[int'(i_req_addr) + i]) << (8 * i));
      if (!i_req_unsigned && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 1);
    end
    q.push_back('{cyc + RL - 1, v[31:0], e});
  endtask
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      q.delete();
      clear_left = 16;
      on = 1;
      foreach (mm[i]) mm[i] = 8'h00;
    end else if (clear_left != 0) clear_left--;
    else if (i_req_valid) model_req();
  end
  always @(negedge clk)
    if (on) begin
      bit ev;
      ev = q.size() != 0 && q[0].due == cyc;
      chk("clearing", 32'(o_clearing), 32'(clear_left != 0));
      chk("req_ready", 32'(o_req_ready), 32'(clear_left == 0 && !rst));
      chk("rsp_valid", 32'(o_rsp_valid), 32'(ev));
      if (ev) begin
        chk("rsp_rdata", o_rsp_rdata, q[0].d);
        chk("rsp_err", 32'(o_rsp_err), 32'(q[0].e));
        obs.push_back('{cyc, o_rsp_rdata, o_rsp_err});
        void'(q.pop_front());
      end
    end
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic req(input logic we, input logic [5:0] a, input logic [1:0] sz, input logic u, input logic [31:0] wd);
    i_req_valid = 1; i_req_we = we; i_req_addr = a; i_req_size = sz; i_req_unsigned = u; i_req_wdata = wd;
    idle(1);
    i_req_valid = 0;
  endtask
  task automatic count_clear(input string nm);
    int n;
    n = 0;
    while (o_clearing === 1'b1 && n < 100) begin
      idle(1);
      n++;
    end
    chk(nm, 32'(n), 32'd16);
    chk({nm, "_ready"}, 32'(o_req_ready), 32'd1);
  endtask
  initial begin
    int c0;
    idle(1);
    rst = 0;
    chk("reset_ready", 32'(o_req_ready), 32'd0);
    chk("reset_valid", 32'(o_rsp_valid), 32'd0);
    chk("reset_rdata", o_rsp_rdata, 32'd0);
    chk("reset_err", 32'(o_rsp_err), 32'd0);
    chk("reset_clearing", 32'(o_clearing), 32'd1);
    count_clear("clear_cycles");
    obs.delete();
    for (int w = 0; w < 16; w++) req(0, 6'(w * 4), 2'd2, 0, 0);
    idle(RL + 1);
    chk("scan_count", 32'(obs.size()), 32'd16);
    obs.delete();
    req(1, 6'h08, 2'd2, 0, 32'hA1B2C3D4);
    req(0, 6'h09, 2'd0, 1, 0);
    req(0, 6'h08, 2'd0, 0, 0);
    req(0, 6'h0A, 2'd1, 0, 0);
    idle(RL + 1);
    chk("ext_count", 32'(obs.size()), 32'd4);
    if (obs.size() == 4) begin
      chk("store_rdata", obs[0].d, 32'h0);
      chk("lbu_09", obs[1].d, 32'h000000C3);
      chk("lb_08", obs[2].d, 32'hFFFFFFD4);
      chk("lh_0a", obs[3].d, 32'hFFFFA1B2);
    end
    obs.delete();
    req(1, 6'h0C, 2'd2, 0, 32'h11223344);
    req(1, 6'h0E, 2'd1, 0, 32'h0000BEEF);
    req(0, 6'h0C, 2'd2, 0, 0);
    idle(RL + 1);
    chk("merge_count", 32'(obs.size()), 32'd3);
    if (obs.size() == 3) chk("merge_word", obs[2].d, 32'hBEEF3344);
    obs.delete();
    req(1, 6'h04, 2'd2, 0, 32'h55667788);
    req(1, 6'h05, 2'd1, 0, 32'h0000FFFF);
    req(0, 6'h06, 2'd2, 0, 0);
    req(0, 6'h04, 2'd2, 0, 0);
    idle(RL + 1);
    chk("misal_count", 32'(obs.size()), 32'd4);
    if (obs.size() == 4) begin
      chk("misal_st_err", 32'(obs[1].e), 32'd1);
      chk("misal_st_rdata", obs[1].d, 32'h0);
      chk("misal_ld_err", 32'(obs[2].e), 32'd1);
      chk("misal_ld_rdata", obs[2].d, 32'h0);
      chk("word04_kept", obs[3].d, 32'h55667788);
    end
    obs.delete();
    req(1, 6'h10, 2'd3, 0, 32'h12345678);
    idle(RL + 1);
    chk("dword_err", obs.size() == 1 ? 32'(obs[0].e) : 32'hDEAD, 32'd1);
    obs.delete();
    c0 = cyc;
    req(0, 6'h08, 2'd2, 0, 0);
    req(0, 6'h0C, 2'd2, 0, 0);
    req(0, 6'h04, 2'd2, 0, 0);
    req(0, 6'h00, 2'd2, 0, 0);
    idle(RL + 1);
    chk("b2b_count", 32'(obs.size()), 32'd4);
    if (obs.size() == 4) begin
      chk("b2b_cyc0", 32'(obs[0].due - c0), 32'd3);
      chk("b2b_cyc3", 32'(obs[3].due - c0), 32'd6);
      chk("b2b_d0", obs[0].d, 32'hA1B2C3D4);
      chk("b2b_d1", obs[1].d, 32'hBEEF3344);
      chk("b2b_d2", obs[2].d, 32'h55667788);
      chk("b2b_d3", obs[3].d, 32'h0);
    end
    obs.delete();
    req(0, 6'h08, 2'd2, 0, 0);
    req(0, 6'h0C, 2'd2, 0, 0);
    rst = 1;
    idle(1);
    rst = 0;
    idle(5);
    chk("mid_clearing", 32'(o_clearing), 32'd1);
    rst = 1;
    idle(2);
    rst = 0;
    count_clear("reclear_cycles");
    chk("dropped", 32'(obs.size()), 32'd0);
    req(0, 6'h08, 2'd2, 0, 0);
    idle(RL + 1);
    chk("after_clear", obs.size() == 1 ? obs[0].d : 32'hDEAD, 32'h0);
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
